// File: rtl/shift_sub_divider.sv
// shift_sub_divider
//   Sequential restoring divider: one quotient bit per SHIFT/SUB state pair.
//   A divisor is latched with Clr_Ld, a dividend is started with Run, and the
//   quotient/remainder are presented on Done after 2*WIDTH clock edges.
//   A zero divisor short-circuits to DONE with Quotient = all ones,
//   Remainder = dividend and Div_By_Zero set.
//
// Ports
//   Clk          rising-edge clock for all state
//   Reset        asynchronous, active-high reset
//   Clr_Ld       in IDLE: load divisor from Din, clear Q and R
//   Run          level; starts a division when sampled high in IDLE
//   Din          divisor (with Clr_Ld) or dividend (with Run)
//   Quotient     Q register (valid when Done=1)
//   Remainder    R register (valid when Done=1)
//   Busy         high in SHIFT or SUB
//   Done         high in DONE
//   Div_By_Zero  high in DONE when the divisor was zero

// Protocol invariants on the divider outputs.
module shift_sub_divider_checker (
  input logic Clk,
  input logic Reset,
  input logic Busy,
  input logic Done,
  input logic Div_By_Zero
);

  busy_done_exclusive_a : assert property (
    @(posedge Clk) disable iff (Reset) !(Busy && Done)
  );

  // A divide-by-zero result is only ever produced without iterating.
  dbz_never_busy_a : assert property (
    @(posedge Clk) disable iff (Reset) Div_By_Zero |-> !Busy
  );

endmodule

module shift_sub_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr_Ld,
  input  logic             Run,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] d_r, d_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [WIDTH-1:0] r_r, r_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             dbz_r, dbz_s;

  // R - D is one bit wider so the top bit is the borrow: borrow clear means
  // R >= D. R never exceeds WIDTH bits after the shift because R < D before it
  // and R is built from at most WIDTH-1 dividend bits before the final shift.
  logic [WIDTH:0]   diff_s;
  logic             r_ge_d_s;

  // Trial subtraction used by the SUB state.
  always_comb begin
    diff_s   = {1'b0, r_r} - {1'b0, d_r};
    r_ge_d_s = ~diff_s[WIDTH];
  end

  // State register and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      d_r     <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      r_r     <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      dbz_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      d_r     <= d_s;
      q_r     <= q_s;
      r_r     <= r_s;
      cnt_r   <= cnt_s;
      dbz_r   <= dbz_s;
    end
  end

  // Next-state and next-datapath logic; everything holds unless a state acts.
  always_comb begin
    state_s = state_r;
    d_s     = d_r;
    q_s     = q_r;
    r_s     = r_r;
    cnt_s   = cnt_r;
    dbz_s   = dbz_r;

    case (state_r)
      IDLE: begin
        if (Clr_Ld) begin
          // Loading a divisor takes priority over starting a division.
          d_s   = Din;
          q_s   = {WIDTH{1'b0}};
          r_s   = {WIDTH{1'b0}};
          dbz_s = 1'b0;
        end else if (Run) begin
          if (d_r != {WIDTH{1'b0}}) begin
            q_s     = Din;
            r_s     = {WIDTH{1'b0}};
            cnt_s   = {CW{1'b0}};
            dbz_s   = 1'b0;
            state_s = SHIFT;
          end else begin
            q_s     = {WIDTH{1'b1}};
            r_s     = Din;
            dbz_s   = 1'b1;
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SHIFT: begin
        // {R,Q} shifts left as one 2*WIDTH register; Q's LSB opens a slot
        // for the next quotient bit.
        r_s     = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
        q_s     = {q_r[WIDTH-2:0], 1'b0};
        state_s = SUB;
      end

      SUB: begin
        if (r_ge_d_s) begin
          r_s = diff_s[WIDTH-1:0];
          q_s = {q_r[WIDTH-1:1], 1'b1};
        end else begin
          r_s = r_r;
          q_s = q_r;
        end
        cnt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end

      DONE: begin
        // Run must drop before returning to IDLE, so a held Run cannot
        // retrigger a new division.
        if (Run) begin
          state_s = DONE;
        end else begin
          state_s = IDLE;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign Quotient    = q_r;
  assign Remainder   = r_r;
  assign Busy        = (state_r == SHIFT) || (state_r == SUB);
  assign Done        = (state_r == DONE);
  assign Div_By_Zero = dbz_r;

  shift_sub_divider_checker u_checker (
    .Clk         (Clk),
    .Reset       (Reset),
    .Busy        (Busy),
    .Done        (Done),
    .Div_By_Zero (Div_By_Zero)
  );

endmodule

// File: tb/tb_shift_sub_divider.sv
// Testbench for shift_sub_divider: stimulus pushes expected results into a
// scoreboard queue, an independent monitor pops and compares on each rising
// Done. Expected values come from plain integer division.
module tb_shift_sub_divider;

  localparam int W = 8;

  logic         Clk;
  logic         Reset;
  logic         Clr_Ld;
  logic         Run;
  logic [W-1:0] Din;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         Div_By_Zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] d_model = 8'd0;

  shift_sub_divider #(.WIDTH(W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Clr_Ld      (Clr_Ld),
    .Run         (Run),
    .Din         (Din),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .Busy        (Busy),
    .Done        (Done),
    .Div_By_Zero (Div_By_Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: compares the result on every rising edge of Done.
  initial begin
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        done_q = 1'b0;
      end else begin
        if (Done && !done_q) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got Done with empty scoreboard");
          end else begin
            e = sb.pop_front();
            if (Quotient !== e.q || Remainder !== e.r || Div_By_Zero !== e.dbz) begin
              errors++;
              $display("FAIL result: got q=%0d r=%0d dbz=%0d expected q=%0d r=%0d dbz=%0d",
                       Quotient, Remainder, Div_By_Zero, e.q, e.r, e.dbz);
            end
          end
        end
        done_q = Done;
      end
    end
  end

  task automatic clr_op(input logic [W-1:0] div);
    @(negedge Clk);
    Clr_Ld = 1'b1;
    Run    = 1'b0;
    Din    = div;
    @(posedge Clk);
    @(negedge Clk);
    Clr_Ld = 1'b0;
    d_model = div;
    chk("clr_q", Quotient, 0);
    chk("clr_r", Remainder, 0);
    chk("clr_busy", Busy, 0);
  endtask

  // Entered at a negedge with Run=1 and Din=dividend already driven.
  task automatic finish_op(input logic [W-1:0] dividend, input bit hold);
    exp_t e;
    int   k;
    int   lat;
    if (d_model == 8'd0) begin
      e.q = 8'hFF; e.r = dividend; e.dbz = 1'b1; lat = 0;
    end else begin
      e.q = dividend / d_model; e.r = dividend % d_model; e.dbz = 1'b0; lat = 2 * W;
    end
    sb.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    Run    = hold;
    Clr_Ld = 1'b0;
    k = 0;
    while (!Done && k < 40) begin
      @(posedge Clk);
      k++;
      @(negedge Clk);
      if (!Done) begin
        // Clr_Ld and Din must be ignored while iterating.
        Clr_Ld = 1'($urandom_range(0, 1));
        Din    = W'($urandom);
      end else begin
        Clr_Ld = 1'b0;
      end
    end
    chk("latency", Done ? k : -1, lat);
    if (!hold) @(posedge Clk);
  endtask

  task automatic run_op(input logic [W-1:0] dividend, input bit hold);
    @(negedge Clk);
    Clr_Ld = 1'b0;
    Run    = 1'b1;
    Din    = dividend;
    finish_op(dividend, hold);
  endtask

  initial begin
    Reset  = 1'b1;
    Clr_Ld = 1'b0;
    Run    = 1'b0;
    Din    = 8'd0;
    #3;
    chk("reset_q", Quotient, 0);
    chk("reset_r", Remainder, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_dbz", Div_By_Zero, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Directed cases.
    clr_op(8'd7);   run_op(8'd100, 1'b0);
    clr_op(8'd1);   run_op(8'd255, 1'b0);
    clr_op(8'd255); run_op(8'd255, 1'b0);
    clr_op(8'd9);   run_op(8'd5, 1'b0);
    clr_op(8'd0);   run_op(8'd200, 1'b0);

    // Clr_Ld and Run together: only the divisor loads.
    @(negedge Clk);
    Clr_Ld = 1'b1;
    Run    = 1'b1;
    Din    = 8'd9;
    @(posedge Clk);
    @(negedge Clk);
    d_model = 8'd9;
    chk("clr_run_busy", Busy, 0);
    chk("clr_run_done", Done, 0);
    chk("clr_run_q", Quotient, 0);
    Clr_Ld = 1'b0;
    Din    = 8'd50;
    finish_op(8'd50, 1'b0);

    // Run held after Done: no restart, then Run low returns to IDLE.
    clr_op(8'd13);
    run_op(8'd200, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      chk("hold_done", Done, 1);
      chk("hold_busy", Busy, 0);
    end
    Run = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("hold_idle_done", Done, 0);
    chk("hold_idle_busy", Busy, 0);
    chk("hold_keep_q", Quotient, 15);
    chk("hold_keep_r", Remainder, 5);
    run_op(8'd77, 1'b0);

    // Reset mid-division aborts everything.
    clr_op(8'd7);
    @(negedge Clk);
    Run = 1'b1;
    Din = 8'd100;
    @(posedge Clk);
    @(negedge Clk);
    Run = 1'b0;
    repeat (7) @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    chk("abort_q", Quotient, 0);
    chk("abort_r", Remainder, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_dbz", Div_By_Zero, 0);
    @(negedge Clk);
    Reset = 1'b0;
    d_model = 8'd0;
    run_op(8'd150, 1'b0);
    clr_op(8'd7);
    run_op(8'd100, 1'b0);

    // Randomized operations, sometimes reusing the previous divisor.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0) clr_op(8'd0);
        else clr_op(W'($urandom_range(1, 255)));
      end
      run_op(W'($urandom), 1'b0);
    end

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sub_divider.md
SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have port Clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Clr_Ld  input  1  in IDLE: load divisor from Din, clear Q and R.
REQ-005 SHALL have port Run  input  1  level; starts a division when sampled high in IDLE.
REQ-006 SHALL have port Din  input  WIDTH  divisor (on Clr_Ld) or dividend (on Run).
REQ-007 SHALL have port Quotient  output  WIDTH  Q register.
REQ-008 SHALL have port Remainder  output  WIDTH  R register.
REQ-009 SHALL have port Busy  output  1  high in SHIFT or SUB.
REQ-010 SHALL have port Done  output  1  high in DONE; results valid.
REQ-011 SHALL have port Div_By_Zero  output  1  registered; high in DONE when divisor was 0.

Function
REQ-012 SHALL hold internal registers D (divisor), Q, R (WIDTH bits each) and an iteration counter of clog2(WIDTH)+1 bits.
REQ-013 SHALL implement states IDLE, SHIFT, SUB, DONE; all outputs decode from state and registers (no combinational input-to-output path).
REQ-014 IDLE, Clr_Ld=1: D<=Din, Q<=0, R<=0, Div_By_Zero<=0, remain IDLE; Run ignored that cycle (Clr_Ld wins).
REQ-015 IDLE, Clr_Ld=0, Run=1, D!=0: Q<=Din, R<=0, counter<=0, Div_By_Zero<=0, next SHIFT.
REQ-016 IDLE, Clr_Ld=0, Run=1, D==0: Q<=all ones, R<=Din, Div_By_Zero<=1, next DONE.
REQ-017 SHIFT: {R,Q} <= {R,Q} shifted left by 1, LSB of Q <= 0; next SUB.
REQ-018 SUB: compare R>=D unsigned; if true R<=R-D and Q[0]<=1, else R,Q unchanged; counter increments.
REQ-019 SUB: if counter (pre-increment) equals WIDTH-1 next DONE, else next SHIFT.
REQ-020 R-D SHALL be computed WIDTH+1 bits wide; borrow bit decides the compare; no overflow possible since R<2*D after shift.
REQ-021 Latency: Run sampled at edge N (D!=0) -> Done=1 after edge N+2*WIDTH (17 cycles for WIDTH=8 including edge N); divide-by-zero -> Done=1 after edge N.
REQ-022 DONE: hold Q, R, Div_By_Zero; stay while Run=1; Run=0 -> IDLE (results stay on outputs until next Clr_Ld/Run).
REQ-023 Run held high across DONE->IDLE SHALL NOT retrigger; new operation requires Run low for at least one cycle in DONE.
REQ-024 Clr_Ld and Din SHALL be ignored in SHIFT, SUB, DONE; Run ignored in SHIFT, SUB.
REQ-025 Quotient/Remainder during SHIFT/SUB show intermediate values and are valid only when Done=1.

Reset
REQ-026 Reset=1 SHALL immediately (asynchronously) force state IDLE, D=0, Q=0, R=0, counter=0, Div_By_Zero=0, Busy=0, Done=0.
REQ-027 Reset asserted mid-operation SHALL abort the division; no partial result retained.
REQ-028 After Reset deassertion, first operation SHALL require Clr_Ld then Run; Run without prior Clr_Ld divides by D=0 per REQ-016.

Verification
REQ-029 Clr_Ld with Din=7, then Run with Din=100 -> Done after 16 further edges, Quotient=14, Remainder=2, Div_By_Zero=0.
REQ-030 D=1, dividend 255 -> Quotient=255, Remainder=0; D=255, dividend 255 -> Quotient=1, Remainder=0; D=9, dividend 5 -> Quotient=0, Remainder=5.
REQ-031 D=0, dividend 200 -> Done one edge after Run, Quotient=255, Remainder=200, Div_By_Zero=1.
REQ-032 Clr_Ld=1 and Run=1 same cycle in IDLE -> only divisor loaded, state stays IDLE, Busy=0; Run held then starts division on next edge with Clr_Ld=0.
REQ-033 Reset pulsed at iteration 4 -> all outputs 0 and IDLE before next edge; subsequent 100/7 run gives 14 rem 2.
REQ-034 Run held high 5 cycles after Done -> Done stays 1, no restart; Run low -> IDLE; Run high again -> new division with same D.
